bartlett_scan_ctrl: RTL and testbench

//  Sweep controller and peak detector on the far side of the Bartlett DOA core. Drives the theta-index

---
 rtl/bartlett_scan_ctrl.sv | 132 +++++++++++++
 tb/tb_bartlett_scan_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bartlett_scan_ctrl.sv
// Bartlett DOA sweep controller: streams theta indices into the core and tracks the argmax of the returned power.
// At most MAX_OUTSTANDING thetas are in flight. Results are consumed in issue order and reported on a one-cycle done pulse.
module bartlett_scan_ctrl #(
    parameter int NUM_SIZE        = 32,
    parameter int THETA_COUNT     = 19,
    parameter int IDX_W           = $clog2(THETA_COUNT) + 1,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [IDX_W-1:0]      peak_idx,
    output logic [NUM_SIZE-1:0]   peak_pow,
    output logic                  proto_err,
    output logic [IDX_W-1:0]      m_axis_theta_tdata,
    output logic                  m_axis_theta_tvalid,
    output logic                  m_axis_theta_tlast,
    output logic                  m_axis_theta_tuser,
    input  logic                  m_axis_theta_tready,
    input  logic [2*NUM_SIZE-1:0] s_axis_p_tdata,
    input  logic                  s_axis_p_tvalid,
    input  logic                  s_axis_p_tlast,
    input  logic                  s_axis_p_tuser,
    output logic                  s_axis_p_tready
);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(THETA_COUNT - 1);
    localparam logic [OUT_W-1:0] MAX_OUT  = OUT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

    state_t              state;
    logic [IDX_W-1:0]    issue_cnt;
    logic [IDX_W-1:0]    recv_cnt;
    logic [OUT_W-1:0]    outstanding;
    logic                theta_hs;
    logic                res_hs;
    logic                res_is_last;
    logic [NUM_SIZE-1:0] res_pow;
    logic                unused_inputs;

    // Issue stalls only on credit; tvalid cannot fall before its handshake because credit
    // only shrinks on a theta handshake.
    assign m_axis_theta_tvalid = (state == SWEEP) && (outstanding < MAX_OUT);
    assign m_axis_theta_tdata  = issue_cnt;
    assign m_axis_theta_tlast  = m_axis_theta_tvalid && (issue_cnt == LAST_IDX);
    assign m_axis_theta_tuser  = m_axis_theta_tvalid && (issue_cnt == '0);

    // With nothing in flight there is no result we could legitimately accept.
    assign s_axis_p_tready = ((state == SWEEP) || (state == DRAIN)) && (outstanding != '0);

    assign theta_hs    = m_axis_theta_tvalid && m_axis_theta_tready;
    assign res_hs      = s_axis_p_tvalid && s_axis_p_tready;
    assign res_is_last = (recv_cnt == LAST_IDX);
    assign res_pow     = s_axis_p_tdata[NUM_SIZE-1:0];

    assign unused_inputs = ^{s_axis_p_tuser, s_axis_p_tdata[2*NUM_SIZE-1:NUM_SIZE]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            peak_idx    <= '0;
            peak_pow    <= '0;
            proto_err   <= 1'b0;
            issue_cnt   <= '0;
            recv_cnt    <= '0;
            outstanding <= '0;
        end else begin
            done <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= SWEEP;
                        busy        <= 1'b1;
                        proto_err   <= 1'b0;
                        peak_pow    <= '0;
                        issue_cnt   <= '0;
                        recv_cnt    <= '0;
                        outstanding <= '0;
                    end
                end
                SWEEP: begin
                    if (theta_hs && (issue_cnt == LAST_IDX)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (res_hs && res_is_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Handshakes are impossible in IDLE, so these never fight the start-time clears.
            if (theta_hs) begin
                issue_cnt <= issue_cnt + 1'b1;
            end

            case ({theta_hs, res_hs})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase

            if (res_hs) begin
                recv_cnt <= recv_cnt + 1'b1;
                // Strict compare keeps the lowest index on ties.
                if ((recv_cnt == '0) || (res_pow > peak_pow)) begin
                    peak_pow <= res_pow;
                    peak_idx <= recv_cnt;
                end
                if (s_axis_p_tlast != res_is_last) begin
                    proto_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bartlett_scan_ctrl.sv
// Directed bench for bartlett_scan_ctrl: a latency-configurable result responder plus per-scenario checks.
`timescale 1ns/1ps
module tb_bartlett_scan_ctrl;
    localparam int NS = 32;
    localparam int TC = 19;
    localparam int IW = $clog2(TC) + 1;
    localparam int MO = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            busy;
    logic            done;
    logic [IW-1:0]   peak_idx;
    logic [NS-1:0]   peak_pow;
    logic            proto_err;
    logic [IW-1:0]   m_axis_theta_tdata;
    logic            m_axis_theta_tvalid;
    logic            m_axis_theta_tlast;
    logic            m_axis_theta_tuser;
    logic            m_axis_theta_tready;
    logic [2*NS-1:0] s_axis_p_tdata;
    logic            s_axis_p_tvalid;
    logic            s_axis_p_tlast;
    logic            s_axis_p_tuser;
    logic            s_axis_p_tready;

    bartlett_scan_ctrl #(.NUM_SIZE(NS), .THETA_COUNT(TC), .IDX_W(IW), .MAX_OUTSTANDING(MO)) dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .busy                (busy),
        .done                (done),
        .peak_idx            (peak_idx),
        .peak_pow            (peak_pow),
        .proto_err           (proto_err),
        .m_axis_theta_tdata  (m_axis_theta_tdata),
        .m_axis_theta_tvalid (m_axis_theta_tvalid),
        .m_axis_theta_tlast  (m_axis_theta_tlast),
        .m_axis_theta_tuser  (m_axis_theta_tuser),
        .m_axis_theta_tready (m_axis_theta_tready),
        .s_axis_p_tdata      (s_axis_p_tdata),
        .s_axis_p_tvalid     (s_axis_p_tvalid),
        .s_axis_p_tlast      (s_axis_p_tlast),
        .s_axis_p_tuser      (s_axis_p_tuser),
        .s_axis_p_tready     (s_axis_p_tready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [NS-1:0] pow_lo [TC];
    logic [NS-1:0] pow_hi [TC];
    logic          tlast_tab [TC];

    int            obs_issued, obs_order_bad, obs_tuser_bad, obs_stall_bad, obs_max_out;
    int            obs_done_cnt, obs_done_lag, obs_results, obs_busy_bad, obs_span;
    bit            obs_timeout;
    logic [IW-1:0] obs_peak_idx;
    logic [NS-1:0] obs_peak_pow;
    logic          obs_proto;

    task automatic do_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Drives theta tready and returns results 'lat' cycles after each theta handshake, in order.
    // Records observations; the caller does the comparisons.
    task automatic run_sweep(input int lat, input int rdy_pct, input int abort_at, input int start_iter);
        int            due_q[$];
        int            idx_q[$];
        int            iter, last_res_iter, done_iter, outst, first_iss, head;
        bit            th_hs, r_hs, holding, prev_stall;
        logic [IW-1:0] prev_dat;
        logic          prev_last, prev_user;
        iter = 0; last_res_iter = -100; done_iter = -1; outst = 0; first_iss = -1;
        prev_stall = 1'b0; prev_dat = '0; prev_last = 1'b0; prev_user = 1'b0;
        obs_issued = 0; obs_order_bad = 0; obs_tuser_bad = 0; obs_stall_bad = 0; obs_max_out = 0;
        obs_done_cnt = 0; obs_done_lag = -1; obs_results = 0; obs_busy_bad = 0; obs_span = -1;
        obs_timeout = 1'b0; obs_peak_idx = '0; obs_peak_pow = '0; obs_proto = 1'b0;
        m_axis_theta_tready = (int'($urandom_range(0, 99)) < rdy_pct);
        while (1'b1) begin
            @(negedge clk);
            th_hs = m_axis_theta_tvalid && m_axis_theta_tready;
            r_hs  = s_axis_p_tvalid && s_axis_p_tready;
            if (prev_stall && (m_axis_theta_tvalid !== 1'b1 || m_axis_theta_tdata !== prev_dat ||
                               m_axis_theta_tlast !== prev_last || m_axis_theta_tuser !== prev_user))
                obs_stall_bad++;
            prev_stall = m_axis_theta_tvalid && !m_axis_theta_tready;
            prev_dat   = m_axis_theta_tdata;
            prev_last  = m_axis_theta_tlast;
            prev_user  = m_axis_theta_tuser;
            if (m_axis_theta_tvalid === 1'b1) begin
                if (m_axis_theta_tdata !== IW'(obs_issued)) obs_order_bad++;
                if (m_axis_theta_tuser !== (obs_issued == 0)) obs_tuser_bad++;
                if (m_axis_theta_tlast !== (obs_issued == TC - 1)) obs_tuser_bad++;
            end else if (m_axis_theta_tuser !== 1'b0 || m_axis_theta_tlast !== 1'b0) begin
                obs_tuser_bad++;
            end
            if (done_iter < 0 && done !== 1'b1 && busy !== 1'b1) obs_busy_bad++;
            if (done === 1'b1) begin
                obs_done_cnt++;
                if (done_iter < 0) begin
                    done_iter    = iter;
                    obs_done_lag = iter - last_res_iter;
                    obs_peak_idx = peak_idx;
                    obs_peak_pow = peak_pow;
                    obs_proto    = proto_err;
                    if (busy !== 1'b0) obs_busy_bad++;
                end
            end
            if (th_hs) begin
                if (first_iss < 0) first_iss = iter;
                obs_span = iter - first_iss;
                idx_q.push_back(obs_issued);
                due_q.push_back(iter + lat);
                obs_issued++;
            end
            if (r_hs) begin
                obs_results++;
                if (obs_results == TC) last_res_iter = iter;
                void'(idx_q.pop_front());
                void'(due_q.pop_front());
            end
            outst = outst + (th_hs ? 1 : 0) - (r_hs ? 1 : 0);
            if (outst > obs_max_out) obs_max_out = outst;
            holding = s_axis_p_tvalid && !r_hs;
            if (done_iter >= 0 && iter >= done_iter + 3) break;
            if (abort_at > 0 && obs_issued >= abort_at) break;
            if (iter > 3000) begin
                obs_timeout = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            iter++;
            m_axis_theta_tready = (int'($urandom_range(0, 99)) < rdy_pct);
            start = (iter == start_iter);
            if (!holding) begin
                if (idx_q.size() > 0 && due_q[0] <= iter) begin
                    head            = idx_q[0];
                    s_axis_p_tvalid = 1'b1;
                    s_axis_p_tdata  = {pow_hi[head], pow_lo[head]};
                    s_axis_p_tlast  = tlast_tab[head];
                    s_axis_p_tuser  = (head == 0);
                end else begin
                    s_axis_p_tvalid = 1'b0;
                    s_axis_p_tlast  = 1'b0;
                end
            end
        end
        s_axis_p_tvalid = 1'b0;
        s_axis_p_tlast  = 1'b0;
        m_axis_theta_tready = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; m_axis_theta_tready = 1'b0;
        s_axis_p_tvalid = 1'b0; s_axis_p_tdata = '0; s_axis_p_tlast = 1'b0; s_axis_p_tuser = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (peak_idx !== '0) begin bad++; $display("FAIL reset_peak_idx: got %0d want 0", peak_idx); end
        total++; if (peak_pow !== '0) begin bad++; $display("FAIL reset_peak_pow: got %0d want 0", peak_pow); end
        total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL reset_proto: got %b want 0", proto_err); end
        total++; if ({m_axis_theta_tvalid, m_axis_theta_tlast, m_axis_theta_tuser} !== 3'b000)
            begin bad++; $display("FAIL reset_theta_ctl: got %b want 000",
                {m_axis_theta_tvalid, m_axis_theta_tlast, m_axis_theta_tuser}); end
        total++; if (s_axis_p_tready !== 1'b0) begin bad++; $display("FAIL reset_p_tready: got %b want 0", s_axis_p_tready); end
    endtask

    task automatic test_ramp();
        for (int i = 0; i < TC; i++) begin
            pow_lo[i] = NS'(10 * i); pow_hi[i] = '0; tlast_tab[i] = (i == TC - 1);
        end
        do_start();
        total++; if (m_axis_theta_tvalid !== 1'b1 || m_axis_theta_tdata !== '0 || m_axis_theta_tuser !== 1'b1)
            begin bad++; $display("FAIL ramp_first_beat: got v=%b d=%0d u=%b want v=1 d=0 u=1",
                m_axis_theta_tvalid, m_axis_theta_tdata, m_axis_theta_tuser); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ramp_busy: got %b want 1", busy); end
        run_sweep(2, 100, 0, -1);
        total++; if (obs_timeout) begin bad++; $display("FAIL ramp_timeout: got timeout want done"); end
        total++; if (obs_issued !== TC) begin bad++; $display("FAIL ramp_issued: got %0d want %0d", obs_issued, TC); end
        total++; if (obs_order_bad !== 0) begin bad++; $display("FAIL ramp_order: got %0d bad beats want 0", obs_order_bad); end
        total++; if (obs_tuser_bad !== 0) begin bad++; $display("FAIL ramp_tuser_tlast: got %0d bad beats want 0", obs_tuser_bad); end
        total++; if (obs_span !== TC - 1) begin bad++; $display("FAIL ramp_issue_rate: got span %0d want %0d", obs_span, TC - 1); end
        total++; if (obs_done_cnt !== 1) begin bad++; $display("FAIL ramp_done_cnt: got %0d want 1", obs_done_cnt); end
        total++; if (obs_done_lag !== 1) begin bad++; $display("FAIL ramp_done_lag: got %0d want 1", obs_done_lag); end
        total++; if (obs_busy_bad !== 0) begin bad++; $display("FAIL ramp_busy_track: got %0d bad cycles want 0", obs_busy_bad); end
        total++; if (obs_peak_idx !== 18) begin bad++; $display("FAIL ramp_peak_idx: got %0d want 18", obs_peak_idx); end
        total++; if (obs_peak_pow !== 180) begin bad++; $display("FAIL ramp_peak_pow: got %0d want 180", obs_peak_pow); end
        total++; if (obs_proto !== 1'b0) begin bad++; $display("FAIL ramp_proto: got %b want 0", obs_proto); end
        total++; if (peak_pow !== 180 || busy !== 1'b0) begin bad++;
            $display("FAIL ramp_hold: got pow=%0d busy=%b want pow=180 busy=0", peak_pow, busy); end
    endtask

    task automatic test_tlast_err();
        for (int i = 0; i < TC; i++) begin
            pow_lo[i] = NS'(i); pow_hi[i] = '0; tlast_tab[i] = (i == 9);
        end
        do_start();
        run_sweep(2, 100, 0, -1);
        total++; if (obs_timeout) begin bad++; $display("FAIL tlast_timeout: got timeout want done"); end
        total++; if (obs_proto !== 1'b1) begin bad++; $display("FAIL tlast_proto: got %b want 1", obs_proto); end
        total++; if (obs_results !== TC) begin bad++; $display("FAIL tlast_results: got %0d want %0d", obs_results, TC); end
        total++; if (obs_done_lag !== 1) begin bad++; $display("FAIL tlast_done_lag: got %0d want 1", obs_done_lag); end
        total++; if (obs_done_cnt !== 1) begin bad++; $display("FAIL tlast_done_cnt: got %0d want 1", obs_done_cnt); end
        total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL tlast_sticky: got %b want 1", proto_err); end
    endtask

    task automatic test_two_peaks();
        for (int i = 0; i < TC; i++) begin
            pow_lo[i] = (i == 3 || i == 7) ? 32'd100 : 32'd5; pow_hi[i] = '0; tlast_tab[i] = (i == TC - 1);
        end
        do_start();
        run_sweep(1, 100, 0, -1);
        total++; if (obs_peak_idx !== 3) begin bad++; $display("FAIL tie_peak_idx: got %0d want 3", obs_peak_idx); end
        total++; if (obs_peak_pow !== 100) begin bad++; $display("FAIL tie_peak_pow: got %0d want 100", obs_peak_pow); end
        total++; if (obs_proto !== 1'b0) begin bad++; $display("FAIL tie_proto_cleared: got %b want 0", obs_proto); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < TC; i++) begin
            pow_lo[i] = NS'((7 * i) % 19); pow_hi[i] = '0; tlast_tab[i] = (i == TC - 1);
        end
        do_start();
        run_sweep(10, 50, 0, -1);
        total++; if (obs_timeout) begin bad++; $display("FAIL bp_timeout: got timeout want done"); end
        total++; if (obs_max_out > MO) begin bad++; $display("FAIL bp_outstanding: got %0d want <=%0d", obs_max_out, MO); end
        total++; if (obs_stall_bad !== 0) begin bad++; $display("FAIL bp_stall_stable: got %0d bad cycles want 0", obs_stall_bad); end
        total++; if (obs_issued !== TC || obs_order_bad !== 0) begin bad++;
            $display("FAIL bp_order: got issued=%0d bad=%0d want issued=%0d bad=0", obs_issued, obs_order_bad, TC); end
        total++; if (obs_peak_idx !== 8 || obs_peak_pow !== 18) begin bad++;
            $display("FAIL bp_peak: got idx=%0d pow=%0d want idx=8 pow=18", obs_peak_idx, obs_peak_pow); end
        total++; if (obs_done_cnt !== 1) begin bad++; $display("FAIL bp_done_cnt: got %0d want 1", obs_done_cnt); end
    endtask

    task automatic test_upper_half();
        for (int i = 0; i < TC; i++) begin
            pow_lo[i] = NS'(i); pow_hi[i] = 32'hFFFF_FFFF; tlast_tab[i] = (i == TC - 1);
        end
        do_start();
        run_sweep(1, 100, 0, -1);
        total++; if (obs_peak_idx !== 18 || obs_peak_pow !== 18) begin bad++;
            $display("FAIL upper_peak: got idx=%0d pow=%0d want idx=18 pow=18", obs_peak_idx, obs_peak_pow); end
    endtask

    task automatic test_reset_mid();
        int done_seen;
        for (int i = 0; i < TC; i++) begin
            pow_lo[i] = NS'(i + 1); pow_hi[i] = '0; tlast_tab[i] = (i == TC - 1);
        end
        do_start();
        run_sweep(3, 100, 7, -1);
        total++; if (obs_issued !== 7) begin bad++; $display("FAIL rst_pre_issue: got %0d want 7", obs_issued); end
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        total++; if (m_axis_theta_tvalid !== 1'b0 || busy !== 1'b0) begin bad++;
            $display("FAIL rst_abandon: got tvalid=%b busy=%b want 0 0", m_axis_theta_tvalid, busy); end
        reset = 1'b0;
        done_seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        total++; if (done_seen !== 0) begin bad++; $display("FAIL rst_no_done: got %0d pulses want 0", done_seen); end
        do_start();
        total++; if (m_axis_theta_tvalid !== 1'b1 || m_axis_theta_tdata !== '0) begin bad++;
            $display("FAIL rst_restart: got v=%b d=%0d want v=1 d=0", m_axis_theta_tvalid, m_axis_theta_tdata); end
        run_sweep(1, 100, 0, 4);
        total++; if (obs_issued !== TC || obs_order_bad !== 0) begin bad++;
            $display("FAIL rst_sweep_order: got issued=%0d bad=%0d want issued=%0d bad=0", obs_issued, obs_order_bad, TC); end
        total++; if (obs_done_cnt !== 1) begin bad++; $display("FAIL rst_done_cnt: got %0d want 1", obs_done_cnt); end
        total++; if (obs_peak_idx !== 18 || obs_peak_pow !== 19) begin bad++;
            $display("FAIL rst_peak: got idx=%0d pow=%0d want idx=18 pow=19", obs_peak_idx, obs_peak_pow); end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_tlast_err();
        test_two_peaks();
        test_backpressure();
        test_upper_half();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
